// File: rtl/tile_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tile_mem_arbiter
//
// Shares one single-port synchronous tile-state RAM between the pixel renderer
// (reads) and the game logic (writes). Renderer reads always win. Game-logic
// writes are parked in a small FIFO and drained only while the VGA timing
// generator reports blanking, so tiles on screen never change mid-frame.
//
// Ports
//   i_clk, i_rst       system clock, synchronous active-high reset
//   i_active           high during the active pixel area
//   i_rd_req/i_rd_addr renderer read request (one pulse per read) and address
//   o_rd_valid         one-cycle pulse, o_rd_data holds the read result
//   o_rd_data          read result, held until the next o_rd_valid
//   i_wr_valid/addr/data, o_wr_ready   game-logic write handshake into the FIFO
//   o_fifo_level       number of buffered writes
//   o_mem_en/we/addr/wdata             registered RAM command
//   i_mem_rdata        RAM read data, one cycle after a read command
//
// Read timing: i_rd_req at cycle N -> RAM command at N+1 -> RAM data at N+2
// -> o_rd_valid at N+3. One read per cycle is sustained.
// -----------------------------------------------------------------------------
module tile_mem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_active,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic                          o_rd_valid,
    output logic [DATA_W-1:0]             o_rd_data,
    input  logic                          i_wr_valid,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    output logic                          o_wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic [DATA_W-1:0]             i_mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              state_p1;
    logic                rd_vld_p2;

    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    count;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign full  = (count == LVL_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Ready depends only on the current level, so a full FIFO refuses a
    // write even in the cycle it pops.
    assign push  = i_wr_valid & ~full;

    // A pop needs both no read contender and blanking in this very cycle; a
    // rising i_active therefore blocks the pop it coincides with.
    assign pop   = ~i_rd_req & ~empty & ~i_active;

    assign o_wr_ready   = ~full;
    assign o_fifo_level = count;

    // The RAM strobes are a pure decode of the registered state.
    assign o_mem_en = (state_p1 != S_IDLE);
    assign o_mem_we = (state_p1 == S_WR);

    // ---- stage p0 -> p1: arbitration, RAM command register, FIFO control
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_p1    <= S_IDLE;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_vld_p2   <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_data   <= '0;
        end else begin
            if (i_rd_req) begin
                state_p1   <= S_RD;
                o_mem_addr <= i_rd_addr;
            end else if (pop) begin
                state_p1    <= S_WR;
                o_mem_addr  <= fifo_addr[rd_ptr];
                o_mem_wdata <= fifo_data[rd_ptr];
                rd_ptr      <= rd_ptr + 1'b1;
            end else begin
                state_p1 <= S_IDLE;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // ---- stage p1 -> p2: RAM performs the read
            rd_vld_p2 <= (state_p1 == S_RD);

            // ---- stage p2 -> output: capture RAM data
            o_rd_valid <= rd_vld_p2;
            if (rd_vld_p2) begin
                o_rd_data <= i_mem_rdata;
            end
        end
    end

    // FIFO payload storage carries no reset; only pointers and level do.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_wr_addr;
            fifo_data[wr_ptr] <= i_wr_data;
        end
    end

endmodule
